// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle for the ALU sequencer.
// The master drives requests and accepts results.
interface alu_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_cmd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carryout;
  logic        out_zero;
  logic        out_overflow;

  modport master (
    output in_valid, in_a, in_b, in_cmd, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_carryout, out_zero, out_overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, out_ready,
    output in_ready, out_valid, out_result,
    output out_carryout, out_zero, out_overflow
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences one ALU operation at a time: latch operands, wait for
// the ALU to settle, capture result, hold until the consumer takes it.
module alu_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_seq_ctrl_if.slave bus,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_cmd,
  input  logic [31:0]   alu_result,
  input  logic          alu_carryout,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  output logic [15:0]   ops_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] LOAD = 8'(SETTLE_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic        accept;
  logic        capture;
  logic        retire;
  logic [31:0] res_q;
  logic        co_q;
  logic        z_q;
  logic        ov_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 8'd1) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers only move on acceptance so the ALU sees
  // stable inputs from one request to the next.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= '0;
      cnt     <= '0;
    end else if (accept) begin
      alu_a   <= bus.in_a;
      alu_b   <= bus.in_b;
      alu_cmd <= bus.in_cmd;
      cnt     <= LOAD;
    end else if (state == SETTLE) begin
      cnt     <= cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_q <= '0;
      co_q  <= 1'b0;
      z_q   <= 1'b0;
      ov_q  <= 1'b0;
    end else if (capture) begin
      res_q <= alu_result;
      co_q  <= alu_carryout;
      z_q   <= alu_zero;
      ov_q  <= alu_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)    ops_done <= '0;
    else if (retire) ops_done <= ops_done + 16'd1;
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_result   = res_q;
  assign bus.out_carryout = co_q;
  assign bus.out_zero     = z_q;
  assign bus.out_overflow = ov_q;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, number of clk cycles ALU inputs are held stable before result capture; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  request carries a valid operation.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_a  input  32  operand A of request.
REQ-007 in_b  input  32  operand B of request.
REQ-008 in_cmd  input  3  ALU command (000 add, 001 sub, 010 xor, 011 slt, 100 and, 101 nand, 110 nor, 111 or); passed through, not decoded.
REQ-009 alu_a  output  32  registered operand A driven to the ALU.
REQ-010 alu_b  output  32  registered operand B driven to the ALU.
REQ-011 alu_cmd  output  3  registered command driven to the ALU.
REQ-012 alu_result  input  32  ALU result.
REQ-013 alu_carryout, alu_zero, alu_overflow  input  1 each  ALU flags.
REQ-014 out_valid  output  1  captured result available.
REQ-015 out_ready  input  1  consumer accepts result this cycle.
REQ-016 out_result  output  32  captured result.
REQ-017 out_carryout, out_zero, out_overflow  output  1 each  captured flags.
REQ-018 ops_done  output  16  count of completed output handshakes.

Function
REQ-019 FSM SHALL have exactly three states: IDLE, SETTLE, HOLD.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD; both registered-state decodes, no combinational path from in_valid or out_ready.
REQ-021 IDLE: in_valid=1 at edge N -> in_a/in_b/in_cmd loaded into alu_a/alu_b/alu_cmd, 8-bit counter loaded with SETTLE_CYCLES, go to SETTLE.
REQ-022 SETTLE: counter decrements each edge; at the edge where counter==1, alu_result and three flags captured into out_* registers and state goes to HOLD; capture therefore occurs at edge N+SETTLE_CYCLES.
REQ-023 alu_a/alu_b/alu_cmd SHALL not change between acceptance and next acceptance (held in SETTLE, HOLD and IDLE).
REQ-024 HOLD: out_* stable; out_ready=1 at an edge -> ops_done increments, state goes to IDLE; out_ready=0 -> remain in HOLD indefinitely.
REQ-025 No bypass: next request accepted no earlier than the edge after the output handshake; minimum period SETTLE_CYCLES+2 cycles per operation.
REQ-026 in_valid while in_ready=0 SHALL be ignored (no latch, no state change); out_ready while out_valid=0 SHALL be ignored.
REQ-027 out_result and out_* flags SHALL retain last captured values in IDLE and SETTLE.
REQ-028 ops_done SHALL wrap 0xFFFF -> 0x0000 with no other effect.
REQ-029 SETTLE_CYCLES=1: capture at edge N+1, out_valid high in cycle N+1..

Reset
REQ-030 reset_n=0 at a rising edge SHALL, in any state, force IDLE and clear alu_a, alu_b, alu_cmd, out_result, out_carryout, out_zero, out_overflow, counter, ops_done to 0; in-flight operation discarded, no handshake counted.
REQ-031 During and after reset: in_ready=1, out_valid=0 from the first edge with reset_n=0; inputs sampled at that edge ignored.

Verification (bench instantiates the team's 32-bit ALU on the alu_* ports)
REQ-032 Add: in_a=0x00030D40, in_b=0x00004E20, cmd=000, SETTLE_CYCLES=4 -> out_valid rises 4 edges after acceptance, out_result=0x00035B60, carryout=0, zero=0, overflow=0, ops_done 0->1 on handshake.
REQ-033 Sub equal: in_a=in_b=0x000186A0, cmd=001 -> out_result=0, zero=1, carryout=1, overflow=0; sub in_a=0x0BEBC200, in_b=0x88CA6C00 -> out_result=0x83215600, overflow=1, carryout=0.
REQ-034 Backpressure: out_ready=0 for 10 cycles in HOLD with in_valid=1 and new operands toggling -> in_ready=0, out_* and alu_* unchanged throughout; out_ready=1 -> IDLE next edge, new request accepted the edge after.
REQ-035 Reset mid-op: reset_n=0 for one edge during SETTLE of an slt (3,5) -> all outputs 0, in_ready=1, ops_done=0, no out_valid pulse; subsequent or (3,5) completes with out_result=0x00000007.
REQ-036 Boundaries: SETTLE_CYCLES=1 xor (3,5) -> out_valid one edge after acceptance, out_result=0x00000006; ops_done preloaded by 65535 handshakes wraps to 0x0000 on the next.
